// File: rtl/coproc_pkg.sv
// Shared types and defaults for the coprocessor frame sequencer.
package coproc_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        SEND    = 2'd3
    } state_t;

    localparam int ERR_TIMEOUT_BIT = 0;
    localparam int ERR_RX_DROP_BIT = 1;

    localparam int DEF_N_BYTES        = 18;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/frame_serializer.sv
// Parallel-load frame register that streams its bytes MS byte first over a
// valid/ready byte port.
module frame_serializer
    import coproc_pkg::*;
#(
    parameter int N_BYTES = DEF_N_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [N_BYTES*8-1:0] load_data,
    input  logic                 flush,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 last_hs
);
    localparam int W     = N_BYTES * 8;
    localparam int CNT_W = $clog2(N_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

    logic [W-1:0]     shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;

    // Handshake: a byte transfers in any cycle where tx_valid && tx_ready;
    // tx_data and tx_valid never change while tx_valid && !tx_ready.
    assign tx_data  = shift_q[W-1 -: 8];
    assign tx_valid = valid_q;
    assign last_hs  = valid_q && tx_ready && (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= load_data;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && tx_ready) begin
            shift_q <= {shift_q[W-9:0], 8'h00};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_hs) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/coproc_sequencer.sv
// Frame controller: collects UART bytes into a frame, issues it to the
// coprocessor, waits with a timeout and streams the result back out.
module coproc_sequencer
    import coproc_pkg::*;
#(
    parameter int N_BYTES        = DEF_N_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [N_BYTES*8-1:0] cp_din,
    output logic                 cp_din_valid,
    input  logic [N_BYTES*8-1:0] cp_dout,
    input  logic                 cp_dout_valid,
    input  logic                 abort,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [1:0]           err_sticky,
    output logic [15:0]          frame_count
);
    localparam int CNT_W = $clog2(N_BYTES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DIN_W = N_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q;
    logic [TMO_W-1:0] tmo_q;
    logic [DIN_W-1:0] din_q;
    logic [1:0]       sticky_q;
    logic [15:0]      count_q;
    logic             rx_write, rx_drop, ser_load, ser_last_hs;

    assign rx_write = (state_q == COLLECT) && rx_valid && !abort;
    assign rx_drop  = (state_q != COLLECT) && rx_valid;
    assign ser_load = (state_q == WAIT) && cp_dout_valid && !abort;

    always_comb begin
        state_d      = state_q;
        cp_din_valid = 1'b0;
        err_timeout  = 1'b0;
        if (abort) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (rx_valid && idx_q == LAST_IDX) state_d = ISSUE;
                ISSUE: begin
                    cp_din_valid = 1'b1;
                    state_d      = WAIT;
                end
                WAIT: begin
                    // A result arriving on the final timeout cycle is still accepted.
                    if (cp_dout_valid) begin
                        state_d = SEND;
                    end else if (tmo_q == TMO_LAST) begin
                        err_timeout = 1'b1;
                        state_d     = COLLECT;
                    end
                end
                SEND: if (ser_last_hs) state_d = COLLECT;
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= COLLECT;
            idx_q    <= '0;
            tmo_q    <= '0;
            din_q    <= '0;
            sticky_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                idx_q <= '0;
            end else if (rx_write) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + CNT_W'(1);
            end
            // Byte k lands in the k-th byte lane counting down from the MS byte.
            if (rx_write) begin
                for (int k = 0; k < N_BYTES; k++) begin
                    if (idx_q == CNT_W'(k)) din_q[DIN_W-1-8*k -: 8] <= rx_data;
                end
            end
            if (state_q == ISSUE) begin
                tmo_q <= '0;
            end else if (state_q == WAIT) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (err_timeout) sticky_q[ERR_TIMEOUT_BIT] <= 1'b1;
            if (rx_drop)     sticky_q[ERR_RX_DROP_BIT] <= 1'b1;
            if (state_q == SEND && ser_last_hs && !abort) count_q <= count_q + 16'd1;
        end
    end

    frame_serializer #(
        .N_BYTES(N_BYTES)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (cp_dout),
        .flush     (abort),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .last_hs   (ser_last_hs)
    );

    assign busy        = (state_q != COLLECT);
    assign cp_din      = din_q;
    assign err_sticky  = sticky_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_coproc_sequencer.sv
// Scoreboard bench for coproc_sequencer with a behavioural echo coprocessor.
module tb_coproc_sequencer;
    localparam int N_BYTES = 18;
    localparam int TMO     = 8;
    localparam int W       = N_BYTES * 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic [W-1:0] cp_din;
    logic         cp_din_valid;
    logic [W-1:0] cp_dout;
    logic         cp_dout_valid;
    logic         abort = 1'b0;
    logic         busy;
    logic         err_timeout;
    logic [1:0]   err_sticky;
    logic [15:0]  frame_count;

    coproc_sequencer #(
        .N_BYTES(N_BYTES),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cp_din(cp_din), .cp_din_valid(cp_din_valid), .cp_dout(cp_dout),
        .cp_dout_valid(cp_dout_valid), .abort(abort), .busy(busy),
        .err_timeout(err_timeout), .err_sticky(err_sticky), .frame_count(frame_count)
    );

    // Clock, cycle counter and tx_ready pattern
    always #5 clk = ~clk;
    int cyc = 0;
    int ready_mode = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Echo coprocessor with selectable latency (cp_lat_m1 + 1 cycles)
    logic [15:0]  vpipe = '0;
    logic [W-1:0] dhold = '0;
    logic [3:0]   cp_lat_m1 = 4'd0;
    logic         cp_respond = 1'b1;
    always @(posedge clk) begin
        vpipe <= {vpipe[14:0], cp_din_valid};
        if (cp_din_valid) dhold <= cp_din;
    end
    assign cp_dout_valid = cp_respond && vpipe[cp_lat_m1];
    assign cp_dout       = dhold;

    // Scoreboard state
    logic [7:0]   exp_q[$];
    logic [W-1:0] exp_din = '0;
    int n_checks = 0, n_fail = 0;
    int last_rx_cyc = 0, din_cyc = 0, tx0_cyc = 0, tmo_cyc = 0;
    int din_pulses = 0, tmo_pulses = 0, hs_count = 0;
    bit first_tx = 1'b0, pending_end = 1'b0, stall_prev = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected queue on every tx handshake
    always @(negedge clk) begin
        if (rst) begin
            if (pending_end) begin
                chk("tx_valid_drop", tx_valid, 1'b0);
                chk("busy_after_last", busy, 1'b0);
                pending_end = 1'b0;
            end
            if (stall_prev && tx_valid) chk("tx_hold", tx_data, held);
            stall_prev = tx_valid && !tx_ready;
            held       = tx_data;
            if (cp_din_valid) begin
                din_pulses++;
                din_cyc = cyc;
                chk("cp_din", cp_din, exp_din);
            end
            if (err_timeout) begin
                tmo_pulses++;
                tmo_cyc = cyc;
            end
            if (tx_valid && first_tx) begin
                tx0_cyc  = cyc;
                first_tx = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got %0h expected no byte", tx_data);
                end else begin
                    chk("tx_data", tx_data, exp_q.pop_front());
                    if (exp_q.size() == 0) pending_end = 1'b1;
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Driver tasks
    task automatic start_frame();
        first_tx   = 1'b1;
        din_pulses = 0;
        hs_count   = 0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx_valid    = 1'b1;
            rx_data     = 8'(base + i);
            last_rx_cyc = cyc;
            if (n == N_BYTES) exp_din[(N_BYTES-i)*8-1 -: 8] = 8'(base + i);
            if (push) exp_q.push_back(8'(base + i));
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(exp_q.size() == 0 && !busy && !tx_valid) && n < budget);
        if (n >= budget && !(exp_q.size() == 0 && !busy && !tx_valid)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: got still busy after %0d cycles expected idle", budget);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_cond_tx(input int budget, input int hs_target);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(tx_valid && hs_count >= hs_target) && n < budget);
        if (!(tx_valid && hs_count >= hs_target)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_tx: got %0d handshakes expected %0d", hs_count, hs_target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cp_din", cp_din, '0);
        chk("rst_cp_din_valid", cp_din_valid, 1'b0);
        chk("rst_err", {err_timeout, err_sticky}, 3'b000);
        chk("rst_frame_count", frame_count, 16'd0);
        rst = 1'b1;

        // Echo with latency check
        start_frame();
        send_frame(8'h00, N_BYTES, 1'b1);
        wait_idle(100);
        chk("din_latency", din_cyc, last_rx_cyc + 1);
        chk("tx0_latency", tx0_cyc, last_rx_cyc + 3);
        chk("din_pulses", din_pulses, 1);
        chk("fc_echo", frame_count, 16'd1);

        // Backpressure
        ready_mode = 1;
        start_frame();
        send_frame(8'h00, N_BYTES, 1'b1);
        wait_idle(300);
        ready_mode = 0;
        chk("fc_backpressure", frame_count, 16'd2);

        // Timeout with no coprocessor response
        cp_respond = 1'b0;
        tmo_pulses = 0;
        start_frame();
        send_frame(8'h20, N_BYTES, 1'b0);
        wait_idle(60);
        cp_respond = 1'b1;
        chk("tmo_pulses", tmo_pulses, 1);
        chk("tmo_cycle", tmo_cyc, din_cyc + TMO);
        chk("sticky_tmo", err_sticky, 2'b01);
        chk("fc_tmo", frame_count, 16'd2);

        // Result on the final timeout cycle wins
        cp_lat_m1  = 4'(TMO - 1);
        tmo_pulses = 0;
        start_frame();
        send_frame(8'h50, N_BYTES, 1'b1);
        wait_idle(100);
        cp_lat_m1 = 4'd0;
        chk("late_no_tmo", tmo_pulses, 0);
        chk("late_tx0", tx0_cyc, din_cyc + TMO + 1);
        chk("fc_late", frame_count, 16'd3);
        chk("sticky_late", err_sticky, 2'b01);

        // Overrun during SEND
        start_frame();
        send_frame(8'h70, N_BYTES, 1'b1);
        wait_cond_tx(20, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        wait_idle(100);
        chk("sticky_overrun", err_sticky, 2'b11);
        chk("fc_overrun", frame_count, 16'd4);

        // Abort after a partial frame
        send_frame(8'h90, 5, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        start_frame();
        send_frame(8'hC0, N_BYTES, 1'b1);
        wait_idle(100);
        chk("abort_din_pulses", din_pulses, 1);
        chk("fc_abort", frame_count, 16'd5);

        // Asynchronous reset mid-SEND
        start_frame();
        send_frame(8'hE0, N_BYTES, 1'b1);
        wait_cond_tx(40, 4);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_sticky", err_sticky, 2'b00);
        chk("mid_rst_fc", frame_count, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        start_frame();
        send_frame(8'h00, N_BYTES, 1'b1);
        wait_idle(100);
        chk("post_rst_fc", frame_count, 16'd1);
        chk("post_rst_sticky", err_sticky, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coproc_sequencer.md
Name: coproc_sequencer

Overview:
- Frame controller between the UART byte streams and the wide coprocessor datapath.
- Assembles N_BYTES received bytes into one frame and issues it to the coprocessor with a single-cycle valid.
- Waits for the coprocessor result, with a timeout, and serialises the result bytes to the UART transmitter.
- One frame is in flight at a time; the block owns sequencing and error reporting for the coprocessor.

Parameters:
- N_BYTES, 18, bytes per frame; coprocessor din/dout width is N_BYTES*8.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before the frame is abandoned (>=2).
- CNT_W, $clog2(N_BYTES+1), byte index width (derived).
- TMO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- cp_din  out  N_BYTES*8  frame to coprocessor
- cp_din_valid  out  1  one-cycle issue strobe
- cp_dout  in  N_BYTES*8  coprocessor result
- cp_dout_valid  in  1  result strobe
- abort  in  1  synchronous: drop current frame, return to COLLECT
- busy  out  1  high in every state other than COLLECT
- err_timeout  out  1  one-cycle pulse on timeout
- err_sticky  out  2  bit0 = timeout seen, bit1 = rx byte dropped; cleared only by reset
- frame_count  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (rst low, async): state COLLECT, byte index 0, all outputs 0, cp_din 0.
- Byte order:
  - Receive byte k (k=0 first) lands in cp_din[(N_BYTES-k)*8-1 -: 8], so the first byte goes in the MS byte.
  - Transmit order is the same: cp_dout MS byte first.
- COLLECT:
  - Each rx_valid writes the byte at the current index and increments the index.
  - The byte with index N_BYTES-1 moves the state to ISSUE on the next edge and resets the index to 0.
- ISSUE (1 cycle): cp_din_valid=1; then go to WAIT and clear the timeout counter.
- cp_din hold: stable from ISSUE until the next COLLECT write.
- WAIT:
  - cp_dout_valid is sampled only in WAIT; a pulse during ISSUE is ignored, so coprocessor latency must be >=1.
  - On cp_dout_valid: latch cp_dout into the tx shift register and go to SEND.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 without valid: pulse err_timeout, set err_sticky[0], go to COLLECT.
- SEND:
  - tx_valid=1 and tx_data = current byte.
  - tx_data holds while tx_valid && !tx_ready.
  - On handshake, advance. The handshake on the last byte goes to COLLECT and increments frame_count.
  - tx_valid drops in the cycle after the last handshake.
- rx_valid outside COLLECT: byte discarded, err_sticky[1] set.
- Same-edge events:
  - rx_valid in the same cycle as the SEND-to-COLLECT transition: the byte is discarded, because the state is still SEND.
  - cp_dout_valid on the final timeout cycle: valid wins, no error.
- abort (any state, priority over all else): next state COLLECT, index 0, tx_valid 0, no error pulse, frame_count unchanged.
- Latency, with the single-register coprocessor (dout_valid one cycle after din_valid):
  - last rx_valid at cycle t
  - cp_din_valid at t+1
  - cp_dout_valid at t+2
  - tx_valid with byte 0 at t+3
- Reset mid-frame: immediate return to reset state; the partial frame is lost.

Decomposition:
- Shared package coproc_pkg:
  - state enum {COLLECT, ISSUE, WAIT, SEND} (2-bit)
  - err_sticky bit positions
  - default N_BYTES, TIMEOUT_CYCLES
- One natural sub-module, frame_serializer: parallel-load N_BYTES register with a valid/ready byte output. SEND logic lives there; the FSM, collection and timeout stay top-level.

Test Plan:
- Echo: send 18 bytes 0x00..0x11 with the echo coprocessor and tx_ready=1 -> cp_din_valid at t+1, tx bytes 0x00..0x11 in order starting t+3, frame_count=1, busy low after the last handshake.
- Backpressure: same frame, tx_ready toggling 1-of-3 cycles -> each tx_data held stable until its handshake, all 18 bytes in order, no drops.
- Timeout: TIMEOUT_CYCLES=8, coprocessor never responds -> err_timeout pulses exactly once, 8 cycles after ISSUE; err_sticky=2'b01; next 18 bytes are processed normally.
- Overrun: rx_valid with 0xAA during SEND -> 0xAA never appears at cp_din or tx; err_sticky[1]=1; current frame output unaffected.
- Abort: abort after 5 collected bytes, then a full 18-byte frame -> output equals only the new frame, frame_count increments by 1.
- Reset mid-SEND: rst low after 4 tx bytes -> tx_valid, busy, err_sticky and frame_count all 0 asynchronously; the following frame completes normally.
